// File: rtl/reg_read_stage.sv
// Register-read stage: operand fetch with writeback forwarding, busy scoreboard
// for RAW/WAW interlock, and a single valid/ready output slot.
module reg_read_stage #(
   parameter int NUM_REGS  = 16,
   parameter int REG_IDX_W = 4,
   parameter int DATA_W    = 64,
   parameter int NUM_SRC   = 2,
   parameter int PAYLOAD_W = 512
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_SRC*REG_IDX_W-1:0]  in_src_idx,
   input  logic [NUM_SRC-1:0]            in_src_valid,
   input  logic [REG_IDX_W-1:0]          in_dest_idx,
   input  logic                          in_dest_valid,
   input  logic [PAYLOAD_W-1:0]          in_payload,
   output logic [NUM_SRC*REG_IDX_W-1:0]  rf_rd_idx,
   input  logic [NUM_SRC*DATA_W-1:0]     rf_rd_data,
   input  logic                          wb_valid,
   input  logic [REG_IDX_W-1:0]          wb_idx,
   input  logic [DATA_W-1:0]             wb_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_SRC*DATA_W-1:0]     out_operand,
   output logic [NUM_SRC-1:0]            out_operand_valid,
   output logic [REG_IDX_W-1:0]          out_dest_idx,
   output logic                          out_dest_valid,
   output logic [PAYLOAD_W-1:0]          out_payload,
   output logic [31:0]                   hazard_stall_cnt
);

   logic [NUM_REGS-1:0]         r_busy;
   logic                        r_out_valid;
   logic [NUM_SRC*DATA_W-1:0]   r_operand;
   logic [NUM_SRC-1:0]          r_operand_valid;
   logic [REG_IDX_W-1:0]        r_dest_idx;
   logic                        r_dest_valid;
   logic [PAYLOAD_W-1:0]        r_payload;
   logic [31:0]                 r_stall_cnt;

   logic [NUM_SRC-1:0]          w_fwd;
   logic [NUM_SRC-1:0]          w_raw;
   logic [NUM_SRC*DATA_W-1:0]   w_operand;
   logic                        w_waw;
   logic                        w_hazard;
   logic                        w_accept;
   logic [NUM_REGS-1:0]         w_busy_nxt;

   // A source being written back this cycle is not a hazard: its value is forwarded.
   always_comb begin
      w_fwd     = '0;
      w_raw     = '0;
      w_operand = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_fwd[k] = wb_valid && (wb_idx == in_src_idx[k*REG_IDX_W +: REG_IDX_W]);
         w_raw[k] = in_src_valid[k] && r_busy[in_src_idx[k*REG_IDX_W +: REG_IDX_W]] && !w_fwd[k];
         if (in_src_valid[k])
            w_operand[k*DATA_W +: DATA_W] = w_fwd[k] ? wb_data : rf_rd_data[k*DATA_W +: DATA_W];
      end
   end

   assign w_waw    = in_dest_valid && r_busy[in_dest_idx] &&
                     !(wb_valid && (wb_idx == in_dest_idx));
   assign w_hazard = (|w_raw) || w_waw;
   assign in_ready = !reset && !flush && !w_hazard && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Clear from writeback first so a same-cycle new claim on that index wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (wb_valid)
         w_busy_nxt[wb_idx] = 1'b0;
      if (w_accept && in_dest_valid)
         w_busy_nxt[in_dest_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy      <= '0;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_busy      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_accept)
            r_out_valid <= 1'b1;
         else if (out_ready)
            r_out_valid <= 1'b0;
      end
   end

   // Output slot data; w_accept is already low during flush, so data holds then.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_operand       <= '0;
         r_operand_valid <= '0;
         r_dest_idx      <= '0;
         r_dest_valid    <= 1'b0;
         r_payload       <= '0;
      end else if (w_accept) begin
         r_operand       <= w_operand;
         r_operand_valid <= in_src_valid;
         r_dest_idx      <= in_dest_idx;
         r_dest_valid    <= in_dest_valid;
         r_payload       <= in_payload;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_stall_cnt <= '0;
      else if (in_valid && w_hazard && !flush && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign rf_rd_idx         = in_src_idx;
   assign out_valid         = r_out_valid;
   assign out_operand       = r_operand;
   assign out_operand_valid = r_operand_valid;
   assign out_dest_idx      = r_dest_idx;
   assign out_dest_valid    = r_dest_valid;
   assign out_payload       = r_payload;
   assign hazard_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios plus randomized traffic against a
// scoreboard-level reference model of the stage.
module tb_reg_read_stage;
   localparam int NR = 16;
   localparam int IW = 4;
   localparam int DW = 64;
   localparam int NS = 2;
   localparam int PW = 512;

   logic             clk = 1'b0;
   logic             reset, flush, in_valid, in_ready;
   logic [NS*IW-1:0] in_src_idx;
   logic [NS-1:0]    in_src_valid;
   logic [IW-1:0]    in_dest_idx;
   logic             in_dest_valid;
   logic [PW-1:0]    in_payload;
   logic [NS*IW-1:0] rf_rd_idx;
   logic [NS*DW-1:0] rf_rd_data;
   logic             wb_valid;
   logic [IW-1:0]    wb_idx;
   logic [DW-1:0]    wb_data;
   logic             out_valid, out_ready;
   logic [NS*DW-1:0] out_operand;
   logic [NS-1:0]    out_operand_valid;
   logic [IW-1:0]    out_dest_idx;
   logic             out_dest_valid;
   logic [PW-1:0]    out_payload;
   logic [31:0]      hazard_stall_cnt;

   reg_read_stage #(.NUM_REGS(NR), .REG_IDX_W(IW), .DATA_W(DW), .NUM_SRC(NS), .PAYLOAD_W(PW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_src_idx(in_src_idx), .in_src_valid(in_src_valid), .in_dest_idx(in_dest_idx),
      .in_dest_valid(in_dest_valid), .in_payload(in_payload), .rf_rd_idx(rf_rd_idx),
      .rf_rd_data(rf_rd_data), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_operand(out_operand),
      .out_operand_valid(out_operand_valid), .out_dest_idx(out_dest_idx),
      .out_dest_valid(out_dest_valid), .out_payload(out_payload),
      .hazard_stall_cnt(hazard_stall_cnt));

   always #5 clk = ~clk;

   logic [DW-1:0] rf [NR];
   always_comb begin
      rf_rd_data = '0;
      for (int k = 0; k < NS; k++)
         rf_rd_data[k*DW +: DW] = rf[rf_rd_idx[k*IW +: IW]];
   end

   // Reference model state
   bit            m_busy [NR];
   logic          m_ov = 1'b0;
   logic [NS*DW-1:0] m_opd = '0;
   logic [NS-1:0] m_opv = '0;
   logic [IW-1:0] m_dest = '0;
   logic          m_destv = 1'b0;
   logic [PW-1:0] m_pay = '0;
   logic [31:0]   m_cnt = '0;
   logic          m_ready, m_haz;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic idle();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_src_valid = '0; in_dest_valid = 1'b0;
      wb_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic set_instr(input int s0, input int s1, input logic [1:0] sv, input int d, input logic dv);
      in_valid = 1'b1;
      in_src_idx = {s1[IW-1:0], s0[IW-1:0]};
      in_src_valid = sv;
      in_dest_idx = d[IW-1:0];
      in_dest_valid = dv;
      for (int i = 0; i < PW/32; i++) in_payload[i*32 +: 32] = $urandom;
   endtask

   // Advance one clock: check in_ready against the model mid-cycle, update the model
   // with the architectural rules, then check every registered output after the edge.
   task automatic cycle();
      logic acc;
      logic [IW-1:0] s;
      @(negedge clk);
      m_haz = 1'b0;
      for (int k = 0; k < NS; k++) begin
         s = in_src_idx[k*IW +: IW];
         if (in_src_valid[k] && m_busy[s] && !(wb_valid && wb_idx == s)) m_haz = 1'b1;
      end
      if (in_dest_valid && m_busy[in_dest_idx] && !(wb_valid && wb_idx == in_dest_idx)) m_haz = 1'b1;
      m_ready = !reset && !flush && !m_haz && (!m_ov || out_ready);
      n_cmp++; if (in_ready !== m_ready) begin n_bad++; $display("FAIL in_ready: got %b want %b @%0t", in_ready, m_ready, $time); end
      n_cmp++; if (rf_rd_idx !== in_src_idx) begin n_bad++; $display("FAIL rf_rd_idx: got %h want %h @%0t", rf_rd_idx, in_src_idx, $time); end
      acc = in_valid && m_ready;
      if (reset) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_ov = 0; m_opd = '0; m_opv = '0; m_dest = '0; m_destv = 0; m_pay = '0; m_cnt = '0;
      end else begin
         if (in_valid && m_haz && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (flush) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_ov = 1'b0;
         end else begin
            if (acc) begin
               m_ov = 1'b1;
               for (int k = 0; k < NS; k++) begin
                  s = in_src_idx[k*IW +: IW];
                  if (!in_src_valid[k]) m_opd[k*DW +: DW] = '0;
                  else if (wb_valid && wb_idx == s) m_opd[k*DW +: DW] = wb_data;
                  else m_opd[k*DW +: DW] = rf[s];
               end
               m_opv = in_src_valid; m_dest = in_dest_idx; m_destv = in_dest_valid; m_pay = in_payload;
            end else if (out_ready) m_ov = 1'b0;
            if (wb_valid) m_busy[wb_idx] = 1'b0;
            if (acc && in_dest_valid) m_busy[in_dest_idx] = 1'b1;
         end
      end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL out_valid: got %b want %b @%0t", out_valid, m_ov, $time); end
      n_cmp++; if (out_operand !== m_opd) begin n_bad++; $display("FAIL out_operand: got %h want %h @%0t", out_operand, m_opd, $time); end
      n_cmp++; if (out_operand_valid !== m_opv) begin n_bad++; $display("FAIL out_operand_valid: got %b want %b @%0t", out_operand_valid, m_opv, $time); end
      n_cmp++; if (out_dest_idx !== m_dest) begin n_bad++; $display("FAIL out_dest_idx: got %h want %h @%0t", out_dest_idx, m_dest, $time); end
      n_cmp++; if (out_dest_valid !== m_destv) begin n_bad++; $display("FAIL out_dest_valid: got %b want %b @%0t", out_dest_valid, m_destv, $time); end
      n_cmp++; if (out_payload !== m_pay) begin n_bad++; $display("FAIL out_payload: got %h want %h @%0t", out_payload, m_pay, $time); end
      n_cmp++; if (hazard_stall_cnt !== m_cnt) begin n_bad++; $display("FAIL stall_cnt: got %0d want %0d @%0t", hazard_stall_cnt, m_cnt, $time); end
   endtask

   task automatic test_reset();
      idle(); reset = 1'b1; set_instr(1, 2, 2'b11, 3, 1'b1);
      cycle(); cycle();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (hazard_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", hazard_stall_cnt); end
      idle();
   endtask

   task automatic test_basic();
      rf[3] = 64'h11; rf[5] = 64'h22;
      set_instr(3, 5, 2'b11, 7, 1'b1);
      cycle();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_operand !== {64'h22, 64'h11}) begin n_bad++; $display("FAIL basic_operand: got %h want 22/11", out_operand); end
      n_cmp++; if (out_dest_idx !== 4'd7) begin n_bad++; $display("FAIL basic_dest: got %h want 7", out_dest_idx); end
   endtask

   task automatic test_raw_fwd();
      set_instr(7, 0, 2'b01, 0, 1'b0);
      repeat (3) cycle();
      n_cmp++; if (hazard_stall_cnt !== 32'd3) begin n_bad++; $display("FAIL raw_cnt: got %0d want 3", hazard_stall_cnt); end
      wb_valid = 1'b1; wb_idx = 4'd7; wb_data = 64'hAB; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_fwd_ready: got %b want 1", in_ready); end
      cycle();
      n_cmp++; if (out_operand[DW-1:0] !== 64'hAB) begin n_bad++; $display("FAIL raw_fwd_operand: got %h want ab", out_operand[DW-1:0]); end
      idle();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      set_instr(1, 2, 2'b11, 0, 1'b0);
      repeat (5) cycle();
      n_cmp++; if (out_operand[DW-1:0] !== 64'hAB) begin n_bad++; $display("FAIL bp_hold: got %h want ab", out_operand[DW-1:0]); end
      out_ready = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      cycle();
      n_cmp++; if (out_payload !== in_payload) begin n_bad++; $display("FAIL bp_new_payload: got %h want %h", out_payload, in_payload); end
      idle();
   endtask

   task automatic test_set_wins();
      set_instr(0, 0, 2'b00, 4, 1'b1); cycle();
      wb_valid = 1'b1; wb_idx = 4'd4; wb_data = {$urandom, $urandom};
      set_instr(0, 0, 2'b00, 4, 1'b1); cycle();
      idle(); set_instr(4, 0, 2'b01, 0, 1'b0); #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL set_wins_busy4: got in_ready %b want 0", in_ready); end
      cycle();
      idle(); wb_valid = 1'b1; wb_idx = 4'd4; cycle();
      idle();
   endtask

   task automatic test_flush();
      logic [31:0] cnt_snap;
      set_instr(0, 0, 2'b00, 2, 1'b1); cycle();
      set_instr(0, 0, 2'b00, 9, 1'b1); cycle();
      cnt_snap = m_cnt;
      flush = 1'b1; set_instr(2, 9, 2'b11, 0, 1'b0); cycle();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      n_cmp++; if (hazard_stall_cnt !== cnt_snap) begin n_bad++; $display("FAIL flush_cnt: got %0d want %0d", hazard_stall_cnt, cnt_snap); end
      flush = 1'b0; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_busy_clear: got in_ready %b want 1", in_ready); end
      cycle();
      idle();
   endtask

   task automatic test_unused_src();
      set_instr(0, 0, 2'b00, 5, 1'b1); cycle();
      set_instr(5, 5, 2'b00, 0, 1'b0); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL unused_ready: got %b want 1", in_ready); end
      cycle();
      n_cmp++; if (out_operand !== '0) begin n_bad++; $display("FAIL unused_operand: got %h want 0", out_operand); end
      n_cmp++; if (out_operand_valid !== 2'b00) begin n_bad++; $display("FAIL unused_opvalid: got %b want 00", out_operand_valid); end
      idle(); wb_valid = 1'b1; wb_idx = 4'd5; cycle();
      idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         set_instr(i, i + 8, 2'b11, 0, 1'b0);
         cycle();
      end
      n_cmp++; if (out_payload !== in_payload) begin n_bad++; $display("FAIL b2b_last_payload: got %h want %h", out_payload, in_payload); end
      idle();
   endtask

   task automatic test_reset_mid();
      set_instr(0, 0, 2'b00, 6, 1'b1); cycle();
      set_instr(6, 0, 2'b01, 0, 1'b0); cycle();
      reset = 1'b1; flush = 1'b1; wb_valid = 1'b1; wb_idx = 4'd6; cycle();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
      n_cmp++; if (hazard_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want 0", hazard_stall_cnt); end
      idle(); set_instr(6, 0, 2'b01, 0, 1'b0); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got in_ready %b want 1", in_ready); end
      cycle();
      idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         flush = ($urandom_range(0, 29) == 0);
         set_instr($urandom_range(0, NR-1), $urandom_range(0, NR-1), 2'($urandom_range(0, 3)),
                   $urandom_range(0, NR-1), 1'($urandom_range(0, 1)));
         in_valid = ($urandom_range(0, 3) != 0);
         wb_valid = ($urandom_range(0, 1) == 1);
         wb_idx = 4'($urandom_range(0, NR-1));
         wb_data = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, NR-1)] = {$urandom, $urandom};
         cycle();
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < NR; i++) rf[i] = {$urandom, $urandom};
      in_src_idx = '0; in_dest_idx = '0; in_payload = '0; wb_idx = '0; wb_data = '0;
      idle();
      test_reset();
      test_basic();
      test_raw_fwd();
      test_backpressure();
      test_set_wins();
      test_flush();
      test_unused_src();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
